// File: rtl/kuuga_mem_arbiter.sv
// kuuga_mem_arbiter
// Round-robin bridge from NUM_CH byte-addressed request ports onto one
// word-addressed single-port block RAM with a fixed pipelined read latency.
// Grants and RAM controls are combinational from the winning request. A
// READ_LATENCY-deep tag pipeline routes each response back to its owner in
// grant order.
module kuuga_mem_arbiter #(
   parameter int NUM_CH       = 2,
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [NUM_CH-1:0]                          ch_req_i,
   input  logic [NUM_CH-1:0]                          ch_we_i,
   input  logic [NUM_CH*(DATA_WIDTH/8)-1:0]           ch_be_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]               ch_addr_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0]               ch_wdata_i,
   output logic [NUM_CH-1:0]                          ch_gnt_o,
   output logic [NUM_CH-1:0]                          ch_rvalid_o,
   output logic [NUM_CH*DATA_WIDTH-1:0]               ch_rdata_o,
   output logic                                       mem_en_o,
   output logic [DATA_WIDTH/8-1:0]                    mem_we_o,
   output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0]                      mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]                      mem_rdata_i
);

   localparam int BE_W           = DATA_WIDTH / 8;
   localparam int OFF_W          = $clog2(BE_W);
   localparam int MEM_ADDR_WIDTH = ADDR_WIDTH - OFF_W;
   localparam int ID_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ID_W:0] NUM_CH_E = (ID_W+1)'(NUM_CH);

   // Illegal parameter combinations stop elaboration.
   if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
      $error("kuuga_mem_arbiter: NUM_CH must be 1..8");
   end
   if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_data_width
      $error("kuuga_mem_arbiter: DATA_WIDTH must be 32 or 64");
   end
   if ((READ_LATENCY < 1) || (READ_LATENCY > 8)) begin : g_bad_latency
      $error("kuuga_mem_arbiter: READ_LATENCY must be 1..8");
   end

   logic [ID_W-1:0]       rr_ptr_r;
   logic [ID_W-1:0]       rr_ptr_nxt_s;
   logic [ID_W:0]         cand_s;
   logic                  take_s;
   logic                  gnt_any_s;
   logic [ID_W-1:0]       winner_s;
   logic                  sel_s;
   logic                  win_we_s;
   logic [BE_W-1:0]       win_be_s;
   logic [ADDR_WIDTH-1:0] win_addr_s;
   logic [DATA_WIDTH-1:0] win_wdata_s;

   logic [READ_LATENCY-1:0] pipe_valid_r;
   logic [READ_LATENCY-1:0] pipe_we_r;
   logic [ID_W-1:0]         pipe_id_r [READ_LATENCY];
   logic                    tail_valid_s;
   logic                    tail_we_s;
   logic [ID_W-1:0]         tail_id_s;
   logic                    rsp_s;

   logic [DATA_WIDTH-1:0]   hold_r [NUM_CH];

   // Round-robin search: first requester at or above rr_ptr, wrapping; no grant in reset.
   always_comb begin
      gnt_any_s = 1'b0;
      winner_s  = '0;
      cand_s    = '0;
      take_s    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand_s    = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
         cand_s    = (cand_s >= NUM_CH_E) ? (cand_s - NUM_CH_E) : cand_s;
         take_s    = rst_n & ~gnt_any_s & ch_req_i[cand_s[ID_W-1:0]];
         winner_s  = take_s ? cand_s[ID_W-1:0] : winner_s;
         gnt_any_s = gnt_any_s | take_s;
      end
   end

   // Select the winner's fields and drive the one-hot grant; everything is zero without a grant.
   always_comb begin
      ch_gnt_o    = '0;
      win_we_s    = 1'b0;
      win_be_s    = '0;
      win_addr_s  = '0;
      win_wdata_s = '0;
      sel_s       = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         sel_s       = gnt_any_s && (winner_s == ID_W'(c));
         ch_gnt_o[c] = sel_s;
         win_we_s    = sel_s ? ch_we_i[c] : win_we_s;
         win_be_s    = sel_s ? ch_be_i[c*BE_W +: BE_W] : win_be_s;
         win_addr_s  = sel_s ? ch_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH] : win_addr_s;
         win_wdata_s = sel_s ? ch_wdata_i[c*DATA_WIDTH +: DATA_WIDTH] : win_wdata_s;
      end
   end

   // RAM side: byte address becomes word address, and a read never drives byte enables.
   always_comb begin
      mem_en_o    = gnt_any_s;
      mem_we_o    = win_we_s ? win_be_s : {BE_W{1'b0}};
      mem_addr_o  = MEM_ADDR_WIDTH'(win_addr_s >> OFF_W);
      mem_wdata_o = win_wdata_s;
   end

   // Pointer moves to one past the granted channel; the last channel wraps to 0.
   always_comb begin
      rr_ptr_nxt_s = (winner_s == ID_W'(NUM_CH - 1)) ? {ID_W{1'b0}} : (winner_s + ID_W'(1));
   end

   // Round-robin pointer register, held when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
      end else if (gnt_any_s) begin
         rr_ptr_r <= rr_ptr_nxt_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // Response tag pipeline: stage 0 takes this cycle's grant, the tail matches RAM data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid_r <= '0;
         pipe_we_r    <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            pipe_id_r[s] <= '0;
         end
      end else begin
         pipe_valid_r[0] <= gnt_any_s;
         pipe_we_r[0]    <= win_we_s;
         pipe_id_r[0]    <= winner_s;
         for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_valid_r[s] <= pipe_valid_r[s-1];
            pipe_we_r[s]    <= pipe_we_r[s-1];
            pipe_id_r[s]    <= pipe_id_r[s-1];
         end
      end
   end

   assign tail_valid_s = pipe_valid_r[READ_LATENCY-1];
   assign tail_we_s    = pipe_we_r[READ_LATENCY-1];
   assign tail_id_s    = pipe_id_r[READ_LATENCY-1];

   // Per-channel read hold: captures RAM data on that channel's read responses only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            hold_r[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (tail_valid_s && !tail_we_s && (tail_id_s == ID_W'(c))) begin
               hold_r[c] <= mem_rdata_i;
            end else begin
               hold_r[c] <= hold_r[c];
            end
         end
      end
   end

   // Response routing: strobe the owner, bypass live RAM data on a read response.
   always_comb begin
      ch_rvalid_o = '0;
      ch_rdata_o  = '0;
      rsp_s       = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         rsp_s          = tail_valid_s && (tail_id_s == ID_W'(c));
         ch_rvalid_o[c] = rsp_s;
         ch_rdata_o[c*DATA_WIDTH +: DATA_WIDTH] = (rsp_s && !tail_we_s) ? mem_rdata_i : hold_r[c];
      end
   end

endmodule

// File: tb/tb_kuuga_mem_arbiter.sv
// Bench for kuuga_mem_arbiter: four channels, four-cycle RAM. Directed
// requests push expected responses into a queue, and a negedge monitor pops
// and compares them whenever a response strobe appears.
module tb_kuuga_mem_arbiter;

   localparam int NUM_CH       = 4;
   localparam int ADDR_WIDTH   = 16;
   localparam int DATA_WIDTH   = 32;
   localparam int READ_LATENCY = 4;
   localparam int BE_W         = 4;
   localparam int MEM_AW       = 14;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic [NUM_CH-1:0]            ch_req;
   logic [NUM_CH-1:0]            ch_we;
   logic [NUM_CH*BE_W-1:0]       ch_be;
   logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata;
   logic [NUM_CH-1:0]            ch_gnt_o;
   logic [NUM_CH-1:0]            ch_rvalid_o;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata_o;
   logic                         mem_en_o;
   logic [BE_W-1:0]              mem_we_o;
   logic [MEM_AW-1:0]            mem_addr_o;
   logic [DATA_WIDTH-1:0]        mem_wdata_o;
   logic [DATA_WIDTH-1:0]        mem_rdata;

   typedef struct {
      int          ch;
      bit          we;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   logic [31:0] ram [0:(1<<MEM_AW)-1];
   logic [31:0] rd_pipe [READ_LATENCY];

   kuuga_mem_arbiter #(
      .NUM_CH       (NUM_CH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ch_req_i    (ch_req),
      .ch_we_i     (ch_we),
      .ch_be_i     (ch_be),
      .ch_addr_i   (ch_addr),
      .ch_wdata_i  (ch_wdata),
      .ch_gnt_o    (ch_gnt_o),
      .ch_rvalid_o (ch_rvalid_o),
      .ch_rdata_o  (ch_rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Preload pattern of the RAM: distinct low byte per word.
   function automatic logic [31:0] pat(input int w);
      return 32'h1122_3300 | 32'(w);
   endfunction

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Block RAM model: byte-write, read data appears READ_LATENCY cycles after enable.
   always @(posedge clk) begin
      if (mem_en_o) begin
         rd_pipe[0] <= ram[mem_addr_o];
         for (int b = 0; b < BE_W; b++) begin
            if (mem_we_o[b]) ram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
         end
      end else begin
         rd_pipe[0] <= 32'hDEAD_BEEF;
      end
      for (int s = 1; s < READ_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
   end
   assign mem_rdata = rd_pipe[READ_LATENCY-1];

   // Monitor: every response strobe must match the oldest expected response.
   exp_t e;
   always @(negedge clk) begin
      if (rst_n) begin
         if ($countones(ch_rvalid_o) > 1)
            check("rvalid_onehot", 64'($countones(ch_rvalid_o)), 64'd1);
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_rvalid_o[c]) begin
               if (exp_q.size() == 0) begin
                  check("rsp_unexpected_ch", 64'(c), 64'hFF);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_ch", 64'(c), 64'(e.ch));
                  check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                  if (!e.we) check("rsp_data", 64'(ch_rdata_o[c*32 +: 32]), 64'(e.data));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input bit we, input logic [3:0] be,
                         input logic [15:0] addr, input logic [31:0] wd);
      ch_req[c]               = 1'b1;
      ch_we[c]                = we;
      ch_be[c*BE_W +: BE_W]   = be;
      ch_addr[c*16 +: 16]     = addr;
      ch_wdata[c*32 +: 32]    = wd;
   endtask

   // One lone transaction: checks the grant cycle and queues the expected response.
   task automatic single(input int c, input bit we, input logic [3:0] be,
                         input logic [15:0] addr, input logic [31:0] wd, input logic [31:0] exp_d);
      set_ch(c, we, be, addr, wd);
      #3;
      check("gnt", 64'(ch_gnt_o), 64'd1 << c);
      check("mem_en", 64'(mem_en_o), 64'd1);
      check("mem_addr", 64'(mem_addr_o), 64'(addr >> 2));
      check("mem_we", 64'(mem_we_o), we ? 64'(be) : 64'd0);
      if (we) check("mem_wdata", 64'(mem_wdata_o), 64'(wd));
      exp_q.push_back('{c, we, exp_d, cyc + READ_LATENCY});
      step();
      ch_req[c] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 64) begin
         step();
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      step();
   endtask

   task automatic check_idle_mem();
      check("idle_mem_en", 64'(mem_en_o), 64'd0);
      check("idle_mem_we", 64'(mem_we_o), 64'd0);
      check("idle_mem_addr", 64'(mem_addr_o), 64'd0);
      check("idle_mem_wdata", 64'(mem_wdata_o), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int w = 0; w < (1 << MEM_AW); w++) ram[w] = pat(w);
      for (int s = 0; s < READ_LATENCY; s++) rd_pipe[s] = 32'h0;
      rst_n    = 1'b0;
      ch_req   = '0;
      ch_we    = '0;
      ch_be    = '0;
      ch_addr  = '0;
      ch_wdata = '0;

      // Reset: a request is visible but must not be granted.
      step();
      set_ch(0, 1'b0, 4'hF, 16'h0010, 32'h0);
      #3;
      check("rst_gnt", 64'(ch_gnt_o), 64'd0);
      check("rst_mem_en", 64'(mem_en_o), 64'd0);
      check("rst_rvalid", 64'(ch_rvalid_o), 64'd0);
      for (int c = 0; c < NUM_CH; c++) check("rst_rdata", 64'(ch_rdata_o[c*32 +: 32]), 64'd0);
      ch_req = '0;
      step();
      rst_n = 1'b1;
      step();
      check_idle_mem();

      // Single read of 0x0010 -> word 4, then the hold register keeps the data.
      single(0, 1'b0, 4'hF, 16'h0010, 32'h0, 32'h1122_3304);
      drain();
      check("hold_ch0", 64'(ch_rdata_o[0 +: 32]), 64'h1122_3304);
      check("hold_rvalid", 64'(ch_rvalid_o), 64'd0);

      // Byte write on ch1 then read back; only byte 1 changes.
      single(1, 1'b1, 4'b0010, 16'h0008, 32'hAABB_CCDD, 32'h0);
      single(1, 1'b0, 4'hF, 16'h0008, 32'h0, 32'h1122_CC02);
      // Write with no byte enables is still granted and changes nothing.
      single(3, 1'b1, 4'b0000, 16'h0008, 32'hFFFF_FFFF, 32'h0);
      single(3, 1'b0, 4'hF, 16'h0008, 32'h0, 32'h1122_CC02);
      // Misaligned address drops the byte offset.
      single(0, 1'b0, 4'hF, 16'h0013, 32'h0, 32'h1122_3304);
      drain();
      check("hold_ch1", 64'(ch_rdata_o[32 +: 32]), 64'h1122_CC02);
      check("hold_ch3", 64'(ch_rdata_o[96 +: 32]), 64'h1122_CC02);
      check_idle_mem();

      // Reset clears hold registers, then round-robin from pointer 0.
      rst_n = 1'b0;
      #2;
      for (int c = 0; c < NUM_CH; c++) check("rst2_rdata", 64'(ch_rdata_o[c*32 +: 32]), 64'd0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, 4'hF, 16'(16'h0100 + c*4), 32'h0);
      for (int k = 0; k < 8; k++) begin
         #3;
         check("rr_gnt", 64'(ch_gnt_o), 64'd1 << (k % 4));
         check("rr_addr", 64'(mem_addr_o), 64'(14'h40 + 14'(k % 4)));
         exp_q.push_back('{k % 4, 1'b0, pat(16'h40 + (k % 4)), cyc + READ_LATENCY});
         step();
      end
      ch_req = '0;
      drain();

      // Sixteen back-to-back reads on ch0: one grant per cycle, continuous responses.
      for (int i = 0; i < 16; i++) begin
         set_ch(0, 1'b0, 4'hF, 16'(16'h0200 + i*4), 32'h0);
         #3;
         check("b2b_gnt", 64'(ch_gnt_o), 64'd1);
         check("b2b_addr", 64'(mem_addr_o), 64'(14'h80 + 14'(i)));
         exp_q.push_back('{0, 1'b0, pat(16'h80 + i), cyc + READ_LATENCY});
         step();
      end
      ch_req = '0;
      drain();

      // Reset one cycle after a ch1 read grant: the read is dropped, pointer returns to 0.
      set_ch(1, 1'b0, 4'hF, 16'h0014, 32'h0);
      #3;
      check("mf_gnt", 64'(ch_gnt_o), 64'd2);
      step();
      ch_req = '0;
      rst_n  = 1'b0;
      #3;
      check("mf_rst_rvalid", 64'(ch_rvalid_o), 64'd0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < NUM_CH; c++) check("mf_rdata", 64'(ch_rdata_o[c*32 +: 32]), 64'd0);
      repeat (READ_LATENCY + 2) step();
      set_ch(0, 1'b0, 4'hF, 16'h0018, 32'h0);
      set_ch(2, 1'b0, 4'hF, 16'h001C, 32'h0);
      #3;
      check("mf_next_gnt", 64'(ch_gnt_o), 64'd1);
      exp_q.push_back('{0, 1'b0, 32'h1122_3306, cyc + READ_LATENCY});
      step();
      ch_req[0] = 1'b0;
      #3;
      check("mf_second_gnt", 64'(ch_gnt_o), 64'd4);
      exp_q.push_back('{2, 1'b0, 32'h1122_3307, cyc + READ_LATENCY});
      step();
      ch_req = '0;
      drain();
      check_idle_mem();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
